// File: rtl/snn_inference_sequencer.sv
// Runs one inference of the two-layer spiking network. It latches the image, clears the
// network, issues NUM_STEPS pulses, counts the class spikes and reports the winning class.
module snn_inference_sequencer #(
    parameter int NUM_STEPS  = 16,
    parameter int STEP_CYC   = 4,
    parameter int SAMPLE_DLY = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [24:0]      pixels_in,
    input  logic [1:0]       spk_in,
    output logic [24:0]      pixel_out,
    output logic             pulse,
    output logic             net_clear,
    output logic             busy,
    output logic             done,
    output logic             class_out,
    output logic             tie,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1
);

    localparam int C_W = $clog2(STEP_CYC);

    typedef enum logic [2:0] {IDLE, CLEAR, STEP, DECIDE, DONE} state_t;

    state_t           state_reg;
    logic [C_W-1:0]   cyc_reg;
    logic [7:0]       step_reg;
    logic [CNT_W-1:0] cnt_reg [2];

    logic accept;
    logic sample_en;
    logic last_cyc;
    logic last_step;

    assign accept    = (state_reg == IDLE) && start;
    assign sample_en = (state_reg == STEP) && (cyc_reg == C_W'(SAMPLE_DLY));
    assign last_cyc  = (cyc_reg == C_W'(STEP_CYC - 1));
    assign last_step = (step_reg == 8'(NUM_STEPS - 1));

    // The pulse register is loaded on the edge before each c = 0 cycle, so the strobe
    // lines up with the first cycle of every timestep.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            cyc_reg   <= '0;
            step_reg  <= '0;
            pixel_out <= '0;
            pulse     <= 1'b0;
            net_clear <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            class_out <= 1'b0;
            tie       <= 1'b0;
        end else begin
            pulse     <= 1'b0;
            net_clear <= 1'b0;
            done      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        pixel_out <= pixels_in;
                        busy      <= 1'b1;
                        net_clear <= 1'b1;
                        cyc_reg   <= '0;
                        step_reg  <= '0;
                        state_reg <= CLEAR;
                    end
                end
                CLEAR: begin
                    pulse     <= 1'b1;
                    cyc_reg   <= '0;
                    step_reg  <= '0;
                    state_reg <= STEP;
                end
                STEP: begin
                    if (last_cyc) begin
                        cyc_reg <= '0;
                        if (last_step) begin
                            state_reg <= DECIDE;
                        end else begin
                            step_reg <= step_reg + 8'd1;
                            pulse    <= 1'b1;
                        end
                    end else begin
                        cyc_reg <= cyc_reg + C_W'(1);
                    end
                end
                DECIDE: begin
                    class_out <= (cnt_reg[1] > cnt_reg[0]);
                    tie       <= (cnt_reg[1] == cnt_reg[0]);
                    done      <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // One saturating spike counter per class; the counters stick at all-ones instead of wrapping.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (!reset) begin
                    cnt_reg[gi] <= '0;
                end else if (accept) begin
                    cnt_reg[gi] <= '0;
                end else if (sample_en && spk_in[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign count0 = cnt_reg[0];
    assign count1 = cnt_reg[1];

endmodule

// File: tb/tb_snn_inference_sequencer.sv
// Bench for snn_inference_sequencer: drives whole inferences cycle by cycle and compares
// the results with spike totals computed from the recorded stimulus.
module tb_snn_inference_sequencer;

    localparam int N   = 16;
    localparam int S   = 4;
    localparam int D   = 1;
    localparam int W   = 8;
    localparam int LAT = 3 + N * S;
    localparam int SN  = 12;
    localparam int SW  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, start;
    logic [24:0]  pixels_in;
    logic [1:0]   spk_in;
    logic [24:0]  pixel_out;
    logic         pulse, net_clear, busy, done, class_out, tie;
    logic [W-1:0] count0, count1;

    logic          start_s;
    logic [1:0]    spk_s;
    logic [24:0]   pixel_out_s;
    logic          pulse_s, net_clear_s, busy_s, done_s, class_out_s, tie_s;
    logic [SW-1:0] count0_s, count1_s;

    snn_inference_sequencer #(.NUM_STEPS(N), .STEP_CYC(S), .SAMPLE_DLY(D), .CNT_W(W)) u_dut (
        .clk(clk), .reset(reset), .start(start), .pixels_in(pixels_in), .spk_in(spk_in),
        .pixel_out(pixel_out), .pulse(pulse), .net_clear(net_clear), .busy(busy), .done(done),
        .class_out(class_out), .tie(tie), .count0(count0), .count1(count1)
    );

    snn_inference_sequencer #(.NUM_STEPS(SN), .STEP_CYC(S), .SAMPLE_DLY(D), .CNT_W(SW)) u_sat (
        .clk(clk), .reset(reset), .start(start_s), .pixels_in(25'h0ABCDEF), .spk_in(spk_s),
        .pixel_out(pixel_out_s), .pulse(pulse_s), .net_clear(net_clear_s), .busy(busy_s),
        .done(done_s), .class_out(class_out_s), .tie(tie_s), .count0(count0_s), .count1(count1_s)
    );

    int checks = 0;
    int errors = 0;

    logic         obs_pulse [0:79];
    logic         obs_clear [0:79];
    logic         obs_busy  [0:79];
    logic [W-1:0] obs_c0    [0:79];
    logic [W-1:0] obs_c1    [0:79];
    logic [1:0]   hist      [0:79];
    int           done_cyc, n_done, n_pulse;
    logic         pix_stable;
    logic [W-1:0] fin_c0, fin_c1;
    logic         fin_cls, fin_tie;

    function automatic bit is_sample(input int cyc);
        return (cyc >= 2) && ((cyc - 2) % S == D) && ((cyc - 2) / S < N);
    endfunction

    // Spike total of one class over the recorded sample cycles, saturated at 2^W-1.
    function automatic int model_count(input int cls);
        int sum = 0;
        for (int k = 0; k < N; k++) sum += int'(hist[2 + k * S + D][cls]);
        return (sum > (1 << W) - 1) ? (1 << W) - 1 : sum;
    endfunction

    // mode: 0 const 2'b10, 1 tie pattern, 2 random, 3 random + stray starts,
    //       4 const 2'b10 + start held, 5 const 2'b10 + reset at cycle 30
    task automatic run_inf(input logic [24:0] pix, input int mode);
        done_cyc = -1; n_done = 0; n_pulse = 0; pix_stable = 1'b1;
        pixels_in = pix; start = 1'b1; spk_in = 2'b00;
        @(posedge clk); #1;
        for (int cyc = 1; cyc < 80; cyc++) begin
            if (mode != 4) start = (mode == 3) && (cyc == 10 || cyc == 40);
            pixels_in = 25'($urandom);
            if (mode == 5) reset = (cyc != 30);
            case (mode)
                1: begin
                    if (is_sample(cyc)) spk_in = ((cyc - 2) / S < 5) ? 2'b11 : 2'b00;
                    else                spk_in = $urandom_range(1) ? 2'b11 : 2'b00;
                end
                2, 3:    spk_in = 2'($urandom);
                default: spk_in = 2'b10;
            endcase
            hist[cyc]      = spk_in;
            obs_pulse[cyc] = pulse;
            obs_clear[cyc] = net_clear;
            obs_busy[cyc]  = busy;
            obs_c0[cyc]    = count0;
            obs_c1[cyc]    = count1;
            if (pulse && cyc <= LAT + 1) n_pulse++;
            if (cyc <= LAT && pixel_out !== pix) pix_stable = 1'b0;
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = cyc; fin_c0 = count0; fin_c1 = count1;
                    fin_cls = class_out; fin_tie = tie;
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0; reset = 1'b1; spk_in = 2'b00;
    endtask

    task automatic apply_reset();
        reset = 1'b0; start = 1'b0; start_s = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({pixel_out, pulse, net_clear, busy, done, class_out, tie, count0, count1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {pixel_out, pulse, net_clear, busy, done, class_out, tie, count0, count1});
        end
        $display("reset: outputs after reset checked");
    endtask

    task automatic test_basic();
        run_inf(25'h1555555, 0);
        for (int cyc = 1; cyc <= LAT; cyc++) begin
            logic exp_p;
            exp_p = (cyc >= 2) && ((cyc - 2) % S == 0) && ((cyc - 2) / S < N);
            checks++;
            if (obs_pulse[cyc] !== exp_p) begin
                errors++; $display("FAIL pulse_cyc%0d: got %0b expected %0b", cyc, obs_pulse[cyc], exp_p);
            end
            checks++;
            if (obs_clear[cyc] !== (cyc == 1)) begin
                errors++; $display("FAIL clear_cyc%0d: got %0b expected %0b", cyc, obs_clear[cyc], cyc == 1);
            end
            checks++;
            if (obs_busy[cyc] !== 1'b1) begin
                errors++; $display("FAIL busy_cyc%0d: got %0b expected 1", cyc, obs_busy[cyc]);
            end
        end
        checks++;
        if (done_cyc != LAT) begin errors++; $display("FAIL basic_done_cycle: got %0d expected %0d", done_cyc, LAT); end
        checks++;
        if (n_done != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", n_done); end
        checks++;
        if (fin_c1 !== W'(16) || fin_c0 !== W'(0)) begin
            errors++; $display("FAIL basic_counts: got %0d/%0d expected 0/16", fin_c0, fin_c1);
        end
        checks++;
        if (fin_cls !== 1'b1 || fin_tie !== 1'b0) begin
            errors++; $display("FAIL basic_class: got cls=%0b tie=%0b expected cls=1 tie=0", fin_cls, fin_tie);
        end
        checks++;
        if (obs_busy[LAT + 1] !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got 1 expected 0"); end
        checks++;
        if (!pix_stable) begin errors++; $display("FAIL basic_pixel_hold: got changed expected 1555555"); end
        $display("basic: done at cycle %0d counts %0d/%0d class %0b", done_cyc, fin_c0, fin_c1, fin_cls);
    endtask

    task automatic test_tie();
        run_inf(25'h0F0F0F0, 1);
        checks++;
        if (fin_c0 !== W'(5) || fin_c1 !== W'(5)) begin
            errors++; $display("FAIL tie_counts: got %0d/%0d expected 5/5", fin_c0, fin_c1);
        end
        checks++;
        if (fin_cls !== 1'b0 || fin_tie !== 1'b1) begin
            errors++; $display("FAIL tie_class: got cls=%0b tie=%0b expected cls=0 tie=1", fin_cls, fin_tie);
        end
        $display("tie: counts %0d/%0d tie %0b", fin_c0, fin_c1, fin_tie);
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            logic [24:0] pix;
            int e0, e1;
            pix = 25'($urandom);
            run_inf(pix, 2);
            e0 = model_count(0); e1 = model_count(1);
            checks++;
            if (int'(fin_c0) != e0 || int'(fin_c1) != e1) begin
                errors++; $display("FAIL rand%0d_counts: got %0d/%0d expected %0d/%0d", t, fin_c0, fin_c1, e0, e1);
            end
            checks++;
            if (fin_cls !== (e1 > e0) || fin_tie !== (e1 == e0)) begin
                errors++; $display("FAIL rand%0d_class: got cls=%0b tie=%0b expected cls=%0b tie=%0b",
                                   t, fin_cls, fin_tie, e1 > e0, e1 == e0);
            end
            checks++;
            if (!pix_stable) begin errors++; $display("FAIL rand%0d_pixel_hold: got changed expected %h", t, pix); end
            $display("random %0d: counts %0d/%0d expected %0d/%0d", t, fin_c0, fin_c1, e0, e1);
        end
    endtask

    task automatic test_ignore_start();
        int e0, e1;
        run_inf(25'h1234567, 3);
        e0 = model_count(0); e1 = model_count(1);
        checks++;
        if (n_pulse != N) begin errors++; $display("FAIL ignore_pulses: got %0d expected %0d", n_pulse, N); end
        checks++;
        if (n_done != 1 || done_cyc != LAT) begin
            errors++; $display("FAIL ignore_done: got %0d at cycle %0d expected 1 at %0d", n_done, done_cyc, LAT);
        end
        checks++;
        if (int'(fin_c0) != e0 || int'(fin_c1) != e1) begin
            errors++; $display("FAIL ignore_counts: got %0d/%0d expected %0d/%0d", fin_c0, fin_c1, e0, e1);
        end
        $display("ignore_start: %0d pulses, %0d done", n_pulse, n_done);
    endtask

    task automatic test_held_start();
        run_inf(25'h1FFFFFF, 4);
        checks++;
        if (done_cyc != LAT) begin errors++; $display("FAIL held_done_cycle: got %0d expected %0d", done_cyc, LAT); end
        checks++;
        if (obs_busy[LAT + 1] !== 1'b0) begin errors++; $display("FAIL held_idle_gap: got busy 1 expected 0"); end
        checks++;
        if (obs_clear[LAT + 2] !== 1'b1 || obs_busy[LAT + 2] !== 1'b1) begin
            errors++; $display("FAIL held_restart: got clear=%0b busy=%0b expected 1/1",
                               obs_clear[LAT + 2], obs_busy[LAT + 2]);
        end
        checks++;
        if (n_pulse != N) begin errors++; $display("FAIL held_pulses: got %0d expected %0d", n_pulse, N); end
        $display("held_start: restart clear at cycle %0d = %0b", LAT + 2, obs_clear[LAT + 2]);
    endtask

    task automatic test_reset_mid();
        int late_pulses = 0;
        apply_reset();
        run_inf(25'h0AAAAAA, 5);
        for (int cyc = 31; cyc < 80; cyc++) if (obs_pulse[cyc]) late_pulses++;
        checks++;
        if (obs_busy[31] !== 1'b0) begin errors++; $display("FAIL midreset_busy: got 1 expected 0"); end
        checks++;
        if (obs_c0[31] !== '0 || obs_c1[31] !== '0) begin
            errors++; $display("FAIL midreset_counts: got %0d/%0d expected 0/0", obs_c0[31], obs_c1[31]);
        end
        checks++;
        if (late_pulses != 0 || n_done != 0) begin
            errors++; $display("FAIL midreset_abort: got pulses=%0d done=%0d expected 0/0", late_pulses, n_done);
        end
        run_inf(25'h0555555, 0);
        checks++;
        if (done_cyc != LAT || fin_c1 !== W'(16)) begin
            errors++; $display("FAIL midreset_rerun: got done %0d count1 %0d expected %0d/16", done_cyc, fin_c1, LAT);
        end
        $display("reset_mid: rerun done at cycle %0d", done_cyc);
    endtask

    task automatic test_saturation();
        int cyc = 0;
        int exp0;
        exp0 = (SN > (1 << SW) - 1) ? (1 << SW) - 1 : SN;
        start_s = 1'b1; spk_s = 2'b01;
        @(posedge clk); #1;
        start_s = 1'b0;
        cyc = 1;
        while (!done_s && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc != 3 + SN * S) begin errors++; $display("FAIL sat_latency: got %0d expected %0d", cyc, 3 + SN * S); end
        checks++;
        if (int'(count0_s) != exp0 || count1_s !== '0) begin
            errors++; $display("FAIL sat_counts: got %0d/%0d expected %0d/0", count0_s, count1_s, exp0);
        end
        checks++;
        if (class_out_s !== 1'b0 || tie_s !== 1'b0) begin
            errors++; $display("FAIL sat_class: got cls=%0b tie=%0b expected 0/0", class_out_s, tie_s);
        end
        spk_s = 2'b00;
        $display("saturation: count0 %0d after %0d cycles", count0_s, cyc);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; pixels_in = '0; spk_in = '0;
        start_s = 1'b0; spk_s = '0;
        test_reset();
        test_basic();
        test_tie();
        test_random();
        test_ignore_start();
        test_held_start();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
